// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud select codes, divisor helper, FSM states and status constants
package uart_pkg;
  localparam logic [1:0] BPS_9600   = 2'b00;
  localparam logic [1:0] BPS_19200  = 2'b01;
  localparam logic [1:0] BPS_38400  = 2'b10;
  localparam logic [1:0] BPS_921600 = 2'b11;
  localparam logic FREE = 1'b0;
  localparam logic BUSY = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic [12:0] bps_div(input int clk_hz, input logic [1:0] sel);
    int baud;
    baud = sel == BPS_9600 ? 9600 : sel == BPS_19200 ? 19200 : sel == BPS_38400 ? 38400 : 921600;
    return 13'(clk_hz / baud - 1);
  endfunction
endpackage

// File: rtl/uart_send_if.sv
// uart_send_if: valid/ready byte handshake into the UART transmitter
interface uart_send_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter pulsing bit_end every div+1 enabled cycles
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [12:0] div,
  output logic        bit_end
);
  logic [12:0] cnt;
  assign bit_end = enable && cnt == div;
  // count 0..div while enabled, restart at each bit boundary, hold at 0 when disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!enable || bit_end) ? 13'd0 : cnt + 13'd1;
endmodule

// File: rtl/uart_send.sv
// uart_send: UART transmitter, start + 8 data LSB first + stop; UART_SEND_PARITY_EN adds a parity bit
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_send_if.slave  up,
  input  logic [1:0]  bps_set,
  output logic        tx,
  output logic        tx_done,
  output logic        tx_state
);
  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  data;
  logic [12:0] div;
  logic        tx_nxt, bit_end, accept;
  assign up.tx_ready = state == IDLE;
  assign tx_state = state == IDLE ? FREE : BUSY;
  assign accept = up.tx_valid && up.tx_ready;
  uart_baud_gen u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .enable(state != IDLE),
    .div(div),
    .bit_end(bit_end)
  );
  // state, bit index and line register; byte and divisor captured only on accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
      data <= '0;
      div <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      tx <= tx_nxt;
      tx_done <= state == STOP && bit_end;
      if (accept) begin
        data <= up.tx_data;
        div <= bps_div(CLK_HZ, bps_set);
      end
    end
  // next state and the line level of that next state, so tx is registered yet aligned
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    case (state)
      IDLE:  if (accept) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end) begin
        idx_nxt = idx + 3'd1;
`ifdef UART_SEND_PARITY_EN
        if (idx == 3'd7) state_nxt = PARITY;
`else
        if (idx == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef UART_SEND_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    tx_nxt = state_nxt == START ? 1'b0 :
             state_nxt == DATA ? data[idx_nxt] :
`ifdef UART_SEND_PARITY_EN
             state_nxt == PARITY ? (^data) ^ (PARITY_ODD != 0) :
`endif
             1'b1;
  end
endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: scoreboard bench decoding tx against queued expected bytes and bit lengths
module tb_uart_send;
  typedef struct {logic [7:0] d; int len;} exp_t;
  localparam int PODD = 0;
`ifdef UART_SEND_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk, rst_n, tx, tx_done, tx_state;
  logic [1:0] bps_set;
  bit mon_en, mon_busy;
  int vectors, errors;
  int len_tab[4] = '{5208, 2604, 1302, 54};
  exp_t sb[$];
  uart_send_if up();
  uart_send #(.CLK_HZ(50_000_000), .PARITY_ODD(PODD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .up(up),
    .bps_set(bps_set),
    .tx(tx),
    .tx_done(tx_done),
    .tx_state(tx_state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_SEND_PARITY_EN
    return {1'b1, (^d) ^ (PODD != 0), d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction
  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (up.tx_ready !== 1'b1 && k < 60000) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 32'(k < 60000), 1);
  endtask
  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || mon_busy) && k < 60000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(k < 60000), 1);
  endtask
  task automatic send(input logic [7:0] d, input logic [1:0] s, input bit push);
    wait_ready();
    up.tx_valid = 1'b1;
    up.tx_data = d;
    bps_set = s;
    if (push) sb.push_back('{d, len_tab[s]});
    @(negedge clk);
    up.tx_valid = 1'b0;
  endtask
  initial begin
    exp_t e;
    logic [10:0] fb;
    logic [7:0] rx;
    int bad;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          check("spurious_frame", 1, 0);
          for (int k = 0; k < 60000 && tx === 1'b0; k++) @(negedge clk);
        end else begin
          e = sb.pop_front();
          fb = frame_bits(e.d);
          bad = 0;
          rx = '0;
          for (int b = 0; b < NB; b++)
            for (int c = 0; c < e.len; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (tx !== fb[b] || tx_state !== 1'b1 || tx_done !== 1'b0) bad++;
              if (c == e.len / 2 && b >= 1 && b <= 8) rx[b-1] = tx;
            end
          check("byte", 32'(rx), 32'(e.d));
          check("frame_shape", bad, 0);
          @(negedge clk);
          check("tx_done", 32'(tx_done), 1);
          check("free_after", 32'(tx_state), 0);
        end
        mon_busy = 1'b0;
      end
    end
  end
  initial begin
    bit seen;
    clk = 1'b0;
    rst_n = 1'b0;
    up.tx_valid = 1'b0;
    up.tx_data = '0;
    bps_set = 2'b11;
    mon_en = 1'b1;
    #12;
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(up.tx_ready), 1);
    check("rst_done", 32'(tx_done), 0);
    check("rst_state", 32'(tx_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 2'b11, 1'b1);
    drain();
    wait_ready();
    up.tx_valid = 1'b1;
    up.tx_data = 8'hA3;
    sb.push_back('{8'hA3, 54});
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = tx_done;
    end
    check("b2b_done_seen", 32'(seen), 1);
    up.tx_data = 8'h0F;
    sb.push_back('{8'h0F, 54});
    @(negedge clk);
    up.tx_valid = 1'b0;
    check("b2b_start", 32'(tx), 0);
    drain();
    send(8'h07, 2'b11, 1'b1);
    drain();
    send(8'h12, 2'b11, 1'b1);
    repeat (150) @(negedge clk);
    check("busy_ready", 32'(up.tx_ready), 0);
    up.tx_valid = 1'b1;
    up.tx_data = 8'hFF;
    @(negedge clk);
    up.tx_valid = 1'b0;
    drain();
    repeat (700) @(negedge clk);
    check("idle_after_ignore", 32'({tx, up.tx_ready}), 32'b11);
    send(8'h5A, 2'b00, 1'b1);
    repeat (1000) @(negedge clk);
    bps_set = 2'b11;
    drain();
    send(8'hC3, 2'b11, 1'b1);
    drain();
    mon_en = 1'b0;
    send(8'h3C, 2'b11, 1'b0);
    repeat (290) @(negedge clk);
    check("pre_reset_busy", 32'(tx_state), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_ready", 32'(up.tx_ready), 1);
    check("mid_rst_state", 32'(tx_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_done || !tx) seen = 1'b1;
    end
    check("no_done_after_reset", 32'(seen), 0);
    mon_en = 1'b1;
    send(8'h81, 2'b11, 1'b1);
    drain();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
